fifoctl_r_w_s: RTL
==================

Name: fifoctl_r_w_s

Overview:
- Synchronous single-clock FIFO controller. It is the address/control initiator for the team's separate-read/write-port DFF RAM (rd_addr, wr_addr, wr_n, data_in/data_out).
- Turns push/pop requests into RAM write strobes and read/write addresses. Tracks occupancy, raises status flags and detects overflow/underflow.
- Sits between a producer/consumer pair and the RAM instance. Data never passes through this block.

Parameters:
- depth, 8, number of RAM words; legal 2..256; need not be a power of two.
- ae_level, 1, almost_empty threshold; legal 1..depth-1.
- af_level, 1, almost_full threshold (words free); legal 1..depth-1.
- err_mode, 0, 0 = sticky error until reset; 1 = error asserted only in the cycle after an illegal request.
- addr_width, derived localparam = ceil(log2(depth)); not user-overridable.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push_req_n  input  1  active-low push request.
- pop_req_n  input  1  active-low pop request.
- we_n  output  1  active-low RAM write enable; connects to the RAM wr_n. The RAM cs_n is tied low at integration.
- wr_addr  output  addr_width  RAM write address (tail pointer).
- rd_addr  output  addr_width  RAM read address (head pointer). RAM read is combinational, so head data is valid whenever empty=0.
- empty  output  1  count==0.
- almost_empty  output  1  count<=ae_level.
- half_full  output  1  count>=(depth+1)/2.
- almost_full  output  1  count>=depth-af_level.
- full  output  1  count==depth.
- error  output  1  overflow/underflow indication per err_mode.

Behaviour:
- Reset (async assert, sync deassert by integrator):
  - wr_addr=0, rd_addr=0, count=0, error=0.
  - empty=1, almost_empty=1, half_full=0, almost_full=0, full=0.
  - Reset mid-operation discards all occupancy immediately. RAM contents are untouched but unreachable.
- State: wr_ptr, rd_ptr (addr_width bits), count (addr_width+1 bits, range 0..depth), error register.
- Flags are pure decode of the registered count, so they are glitch-free and update one cycle after the accepted request.
- push_acc = !push_req_n & (!full | pop_acc).
- pop_acc = !pop_req_n & !empty.
- we_n = !push_acc (combinational); the write lands at wr_addr on the same rising edge.
- On push_acc: wr_ptr increments. On pop_acc: rd_ptr increments.
  - Wrap rule: depth-1 -> 0 (explicit compare, not a power-of-two rollover).
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with push+pop: both accepted. The old head is read combinationally before the edge; the new word overwrites that slot at the edge. count stays depth.
- Empty with push+pop: push accepted, pop rejected → underflow. count becomes 1.
- Overflow: push request while full with no pop request. No write (we_n=1), no pointer change.
- Underflow: pop request while empty. No pointer change.
- error:
  - err_mode=0: set on the edge following any overflow/underflow; held until rst_n.
  - err_mode=1: error = registered (overflow|underflow), high for exactly one cycle per illegal request.
- Latency: accepted push is visible (empty deasserts, rd_addr data valid) on the cycle after the edge.

Optional Feature:
- Macro FIFOCTL_WRDCNT_EN.
- Defined: adds output word_count [addr_width:0], driven directly from the count register. Reset value is 0.
- Undefined: no word_count port. Count stays internal and flags are unchanged.

Decomposition:
- Package fifoctl_pkg holds:
  - err_mode constants ERR_STICKY=0 and ERR_DYNAMIC=1;
  - a clog2 function used to derive addr_width;
  - the flag-threshold helper function for half_full.
- One sub-module, fifoctl_wrap_ptr: parameterised modulo-depth pointer register with async reset and increment enable. Instantiated twice, for the read and write pointers.

Test Plan:
- Reset then idle → empty=1, almost_empty=1, all other flags 0, wr_addr=rd_addr=0, we_n=1.
- depth=8: push 8 times, no pop → wr_addr 1..7 then back to 0 (wrap). half_full rises after push 4, almost_full after push 7, full after push 8. Each push cycle has we_n=0.
- From full (depth=8): push+pop in the same cycle → we_n=0, both pointers advance by 1, full stays 1, error stays 0.
- From full, push only → we_n=1, pointers frozen, error=1 next cycle.
  - err_mode=0: error still 1 after 10 idle cycles.
  - err_mode=1: error returns to 0 after one cycle.
- From empty, push+pop together → push accepted, count=1, empty=0 next cycle, error=1 (underflow).
- depth=5 non-power-of-two: 12 alternating push/pop cycles → rd_addr sequence 0,1,2,3,4,0,1 with no out-of-range address. With FIFOCTL_WRDCNT_EN, word_count toggles between 1 and 0.

Source files
------------

// File: rtl/fifoctl_pkg.sv
// Shared definitions for the FIFO controller: error-mode encodings and
// parameter-derivation helpers used by fifoctl_r_w_s and its pointer sub-module.
package fifoctl_pkg;

    // Error reporting modes
    localparam int ERR_STICKY  = 0;  // error held until reset
    localparam int ERR_DYNAMIC = 1;  // error pulses for one cycle per illegal request

    // Ceiling log2; depth is always >= 2, so the result is always >= 1
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Occupancy at which half_full asserts (rounds up for odd depths)
    function automatic int half_full_level(input int depth);
        return (depth + 1) / 2;
    endfunction

endpackage

// File: rtl/fifoctl_wrap_ptr.sv
// Modulo-depth pointer register. Advances by one when inc is high and wraps
// from depth-1 back to 0 with an explicit compare, so any depth works.
module fifoctl_wrap_ptr #(
    parameter int depth      = 8,
    parameter int addr_width = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    output logic [addr_width-1:0] ptr
);

    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(depth - 1);
    localparam logic [addr_width-1:0] ONE       = addr_width'(1);

    logic [addr_width-1:0] ptr_reg;
    logic [addr_width-1:0] ptr_next;

    // Next pointer: hold, increment, or wrap to zero at the last word
    always_comb begin
        ptr_next = ptr_reg;
        if (inc) begin
            if (ptr_reg == LAST_ADDR) begin
                ptr_next = '0;
            end else begin
                ptr_next = ptr_reg + ONE;
            end
        end
    end

    // Pointer register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/fifoctl_r_w_s.sv
// FIFO controller for a separate read/write port RAM. Converts active-low
// push/pop requests into RAM write strobes and head/tail addresses, tracks
// occupancy and raises status/error flags. Data never passes through here.
// Optional macro FIFOCTL_WRDCNT_EN adds a word_count output.
module fifoctl_r_w_s
    import fifoctl_pkg::*;
#(
    parameter int depth    = 8,
    parameter int ae_level = 1,
    parameter int af_level = 1,
    parameter int err_mode = ERR_STICKY,
    localparam int addr_width = clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_req_n,
    input  logic                  pop_req_n,
    output logic                  we_n,
    output logic [addr_width-1:0] wr_addr,
    output logic [addr_width-1:0] rd_addr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  half_full,
    output logic                  almost_full,
    output logic                  full,
    output logic                  error
`ifdef FIFOCTL_WRDCNT_EN
    ,
    output logic [addr_width:0]   word_count
`endif
);

    localparam int CW = addr_width + 1;

    // Flag thresholds expressed in count width
    localparam logic [CW-1:0] DEPTH_CNT = CW'(depth);
    localparam logic [CW-1:0] AE_CNT    = CW'(ae_level);
    localparam logic [CW-1:0] HF_CNT    = CW'(half_full_level(depth));
    localparam logic [CW-1:0] AF_CNT    = CW'(depth - af_level);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          error_reg;
    logic          error_next;

    logic          full_now;
    logic          empty_now;
    logic          push_acc;
    logic          pop_acc;
    logic          overflow;
    logic          underflow;

    // Index 0 drives the write (tail) pointer, index 1 the read (head) pointer
    logic [1:0]                  ptr_inc;
    logic [1:0][addr_width-1:0]  ptr_val;

    assign full_now  = (count_reg == DEPTH_CNT);
    assign empty_now = (count_reg == '0);

    // A pop is honoured whenever there is data; a push into a full FIFO is
    // only honoured when a simultaneous pop frees the head slot.
    assign pop_acc   = !pop_req_n && !empty_now;
    assign push_acc  = !push_req_n && (!full_now || pop_acc);
    assign overflow  = !push_req_n && full_now && pop_req_n;
    assign underflow = !pop_req_n && empty_now;

    assign ptr_inc[0] = push_acc;
    assign ptr_inc[1] = pop_acc;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
            fifoctl_wrap_ptr #(
                .depth      (depth),
                .addr_width (addr_width)
            ) u_ptr (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (ptr_inc[gi]),
                .ptr   (ptr_val[gi])
            );
        end
    endgenerate

    // Occupancy: +1 on push only, -1 on pop only, hold otherwise
    always_comb begin
        count_next = count_reg;
        if (push_acc && !pop_acc) begin
            count_next = count_reg + ONE_CNT;
        end else if (pop_acc && !push_acc) begin
            count_next = count_reg - ONE_CNT;
        end
    end

    generate
        if (err_mode == ERR_DYNAMIC) begin : g_err_dynamic
            assign error_next = overflow || underflow;
        end else begin : g_err_sticky
            assign error_next = error_reg || overflow || underflow;
        end
    endgenerate

    // Occupancy and error state, discarded immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            error_reg <= error_next;
        end
    end

    // The RAM write lands at the tail on the same edge the push is accepted
    assign we_n    = !push_acc;
    assign wr_addr = ptr_val[0];
    assign rd_addr = ptr_val[1];

    // Flags decode the registered count only, so they never glitch
    assign empty        = empty_now;
    assign almost_empty = (count_reg <= AE_CNT);
    assign half_full    = (count_reg >= HF_CNT);
    assign almost_full  = (count_reg >= AF_CNT);
    assign full         = full_now;
    assign error        = error_reg;

`ifdef FIFOCTL_WRDCNT_EN
    assign word_count = count_reg;
`endif

endmodule
